// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
//   Shared types and constants for the multicycle RV32I(+M) control unit:
//   FSM state enum, major opcodes, funct7 patterns, ALU operation codes,
//   PC-source and writeback-source encodings, and the instruction class enum
//   produced by the decoder.
// -----------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_MUL    = 4'd10,
        ALU_MULH   = 4'd11,
        ALU_MULHSU = 4'd12,
        ALU_MULHU  = 4'd13
    } alu_op_e;

    typedef enum logic [3:0] {
        PC_HOLD   = 4'b0000,
        PC_PLUS4  = 4'b0100,
        PC_REL    = 4'b0110,
        PC_JALR   = 4'b0101
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef enum logic [3:0] {
        CLS_ALU_REG,
        CLS_ALU_IMM,
        CLS_MUL,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR
    } instr_class_e;

    // Base-ISA ALU op for a funct3; alt selects SUB/SRA on the alternate funct7.
    function automatic alu_op_e alu_op_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
//   Purely combinational opcode/funct classification.
//   Ports:
//     opcode_i, funct3_i, funct7_i : instruction fields from the IR
//     cls_o                        : instruction class
//     alu_op_o                     : ALU operation for the class
//     legal_o                      : 1 when the encoding is supported
//   SUPPORT_M = 1 enables MUL/MULH/MULHSU/MULHU; otherwise they are illegal.
// -----------------------------------------------------------------------------
module instr_decoder
    import control_pkg::*;
#(
    parameter int SUPPORT_M = 0
) (
    input  logic [6:0]   opcode_i,
    input  logic [2:0]   funct3_i,
    input  logic [6:0]   funct7_i,
    output instr_class_e cls_o,
    output alu_op_e      alu_op_o,
    output logic         legal_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cls_o    = CLS_ALU_REG;
        alu_op_o = ALU_ADD;
        legal_o  = 1'b1;
        case (opcode_i)
            OPC_OP: begin
                if (funct7_i == F7_BASE) begin
                    alu_op_o = alu_op_from_funct3(funct3_i, 1'b0);
                end else if (funct7_i == F7_ALT && (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
                    alu_op_o = alu_op_from_funct3(funct3_i, 1'b1);
                end else if (SUPPORT_M != 0 && funct7_i == F7_MULDIV && !funct3_i[2]) begin
                    cls_o = CLS_MUL;
                    case (funct3_i[1:0])
                        2'b00:   alu_op_o = ALU_MUL;
                        2'b01:   alu_op_o = ALU_MULH;
                        2'b10:   alu_op_o = ALU_MULHSU;
                        default: alu_op_o = ALU_MULHU;
                    endcase
                end else begin
                    legal_o = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                cls_o = CLS_ALU_IMM;
                // funct7 is only an opcode extension for shifts; elsewhere it is immediate bits.
                alu_op_o = alu_op_from_funct3(funct3_i, funct3_i == 3'b101 && funct7_i == F7_ALT);
                if (funct3_i == 3'b001 && funct7_i != F7_BASE)
                    legal_o = 1'b0;
                if (funct3_i == 3'b101 && funct7_i != F7_BASE && funct7_i != F7_ALT)
                    legal_o = 1'b0;
            end
            OPC_LOAD: begin
                cls_o   = CLS_LOAD;
                legal_o = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                cls_o   = CLS_STORE;
                legal_o = funct3_i inside {3'b000, 3'b001, 3'b010};
            end
            OPC_BRANCH: begin
                cls_o   = CLS_BRANCH;
                legal_o = !(funct3_i inside {3'b010, 3'b011});
            end
            OPC_JALR: begin
                cls_o   = CLS_JALR;
                legal_o = (funct3_i == 3'b000);
            end
            OPC_JAL:   cls_o = CLS_JAL;
            OPC_LUI:   cls_o = CLS_LUI;
            OPC_AUIPC: cls_o = CLS_AUIPC;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Control FSM for a multicycle RV32I(+M) core: FETCH, DECODE, EXECUTE,
//   MEMORY, WRITEBACK, plus a sticky TRAP for illegal instructions and
//   memory timeouts. Emits control only.
//   Inputs : clk, reset (sync, active-high), opcode/funct3/funct7 from IR,
//            branch_taken, mem_ready, mul_done.
//   Outputs: pc_control, ir_write, alu_control, alu_src_imm, alu_op1_pc,
//            wb_sel, register_write_en, mem_req, mem_we, mem_addr_sel,
//            mem_size, mem_unsigned, mul_start, illegal_instr, bus_error,
//            instr_retired.
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int SUPPORT_M   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       branch_taken,
    input  logic       mem_ready,
    input  logic       mul_done,
    output logic [3:0] pc_control,
    output logic       ir_write,
    output logic [3:0] alu_control,
    output logic       alu_src_imm,
    output logic       alu_op1_pc,
    output logic [1:0] wb_sel,
    output logic       register_write_en,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       mul_start,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic       instr_retired
);

    localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

    state_e       state_q, state_d, st;
    logic [7:0]   cnt_q, cnt_d;
    logic         mul_busy_q, mul_busy_d;
    logic         illegal_q, illegal_d;
    logic         bus_err_q, bus_err_d;
    logic         mem_wait;
    logic         timeout_hit;
    instr_class_e cls;
    alu_op_e      alu_op;
    logic         legal;

    instr_decoder #(.SUPPORT_M(SUPPORT_M)) u_decoder (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .cls_o    (cls),
        .alu_op_o (alu_op),
        .legal_o  (legal)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all update together at the edge.
        if (reset) begin
            state_q    <= ST_FETCH;
            cnt_q      <= '0;
            mul_busy_q <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_busy_q <= mul_busy_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Flags are forced low during reset so reset presents pure FETCH outputs.
    assign illegal_instr = illegal_q & ~reset;
    assign bus_error     = bus_err_q & ~reset;

    always_comb begin
        // While reset is high the outputs behave as FETCH with no handshake.
        st                = reset ? ST_FETCH : state_q;
        state_d           = state_q;
        illegal_d         = illegal_q;
        bus_err_d         = bus_err_q;
        mem_wait          = 1'b0;
        timeout_hit       = (cnt_q >= TIMEOUT_C - 8'd1);
        pc_control        = PC_HOLD;
        ir_write          = 1'b0;
        alu_control       = ALU_ADD;
        alu_src_imm       = 1'b0;
        alu_op1_pc        = 1'b0;
        wb_sel            = WB_ALU;
        register_write_en = 1'b0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr_sel      = 1'b0;
        mem_size          = 2'b00;
        mem_unsigned      = 1'b0;
        mul_start         = 1'b0;
        instr_retired     = 1'b0;

        // ALU stays combinational from EXECUTE through WRITEBACK, so its
        // controls are held across all three to keep the result stable.
        if (st inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK}) begin
            alu_control = alu_op;
            alu_src_imm = cls inside {CLS_ALU_IMM, CLS_LOAD, CLS_STORE, CLS_AUIPC};
            alu_op1_pc  = (cls == CLS_AUIPC);
            if (cls inside {CLS_LOAD, CLS_STORE}) begin
                mem_size     = funct3[1:0];
                mem_unsigned = (cls == CLS_LOAD) && funct3[2];
            end
        end

        case (st)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready && !reset) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
                    mem_wait = 1'b1;
                    if (timeout_hit) begin
                        state_d   = ST_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                case (cls)
                    CLS_ALU_REG, CLS_ALU_IMM, CLS_LUI, CLS_AUIPC: state_d = ST_WRITEBACK;
                    CLS_MUL: begin
                        mul_start = !mul_busy_q;
                        if (mul_done)
                            state_d = ST_WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    CLS_BRANCH: begin
                        pc_control    = branch_taken ? PC_REL : PC_PLUS4;
                        instr_retired = 1'b1;
                        state_d       = ST_FETCH;
                    end
                    default: begin  // JAL / JALR
                        register_write_en = 1'b1;
                        wb_sel            = WB_PC4;
                        pc_control        = (cls == CLS_JAL) ? PC_REL : PC_JALR;
                        instr_retired     = 1'b1;
                        state_d           = ST_FETCH;
                    end
                endcase
            end
            ST_MEMORY: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        instr_retired = 1'b1;
                        pc_control    = PC_PLUS4;
                        state_d       = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else begin
                    mem_wait = 1'b1;
                    if (timeout_hit) begin
                        state_d   = ST_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ST_WRITEBACK: begin
                register_write_en = 1'b1;
                case (cls)
                    CLS_LOAD: wb_sel = WB_MEM;
                    CLS_LUI:  wb_sel = WB_IMM;
                    default:  wb_sel = WB_ALU;
                endcase
                pc_control    = PC_PLUS4;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase

        // Wait counter: restarts on any state change and saturates, never wraps.
        if (state_d != state_q)
            cnt_d = '0;
        else if (mem_wait && cnt_q != TIMEOUT_C)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = cnt_q;

        // Marks EXECUTE cycles after the first so mul_start pulses only once.
        mul_busy_d = (state_q == ST_EXECUTE) && (state_d == ST_EXECUTE);
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Directed bench. Two instances share inputs: dut_a (MEM_TIMEOUT=4,
//   SUPPORT_M=0) and dut_m (MEM_TIMEOUT=16, SUPPORT_M=1). Inputs change 1 ns
//   after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       branch_taken, mem_ready, mul_done;

    logic [3:0] a_pc, a_alu, m_pc, m_alu;
    logic [1:0] a_wb, a_size, m_wb, m_size;
    logic       a_irw, a_imm, a_op1pc, a_rwe, a_req, a_we, a_asel, a_uns, a_mstart, a_ill, a_bus, a_ret;
    logic       m_irw, m_imm, m_op1pc, m_rwe, m_req, m_we, m_asel, m_uns, m_mstart, m_ill, m_bus, m_ret;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .SUPPORT_M(0)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .mul_done(mul_done),
        .pc_control(a_pc), .ir_write(a_irw), .alu_control(a_alu), .alu_src_imm(a_imm),
        .alu_op1_pc(a_op1pc), .wb_sel(a_wb), .register_write_en(a_rwe), .mem_req(a_req),
        .mem_we(a_we), .mem_addr_sel(a_asel), .mem_size(a_size), .mem_unsigned(a_uns),
        .mul_start(a_mstart), .illegal_instr(a_ill), .bus_error(a_bus), .instr_retired(a_ret)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(16), .SUPPORT_M(1)) dut_m (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .mul_done(mul_done),
        .pc_control(m_pc), .ir_write(m_irw), .alu_control(m_alu), .alu_src_imm(m_imm),
        .alu_op1_pc(m_op1pc), .wb_sel(m_wb), .register_write_en(m_rwe), .mem_req(m_req),
        .mem_we(m_we), .mem_addr_sel(m_asel), .mem_size(m_size), .mem_unsigned(m_uns),
        .mul_start(m_mstart), .illegal_instr(m_ill), .bus_error(m_bus), .instr_retired(m_ret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0; mul_done = 1'b0;
        set_instr(7'b0010011, 3'b000, 7'b0000000);            // ADDI x1,x0,5
        step(); step();
        #1;
        check("rst_mem_req",  a_req,  1);
        check("rst_ir_write", a_irw,  0);
        check("rst_addr_sel", a_asel, 0);
        check("rst_pc",       a_pc,   0);
        check("rst_retired",  a_ret,  0);

        // ADDI: F D E W
        reset = 1'b0; #1;
        check("addi_F_ir_write", a_irw, 1);
        check("addi_F_mem_req",  a_req, 1);
        step(); #1;
        check("addi_D_mem_req", a_req, 0);
        check("addi_D_rwe",     a_rwe, 0);
        step(); #1;
        check("addi_E_rwe",     a_rwe, 0);
        check("addi_E_alu",     a_alu, 4'b0000);
        step(); #1;
        check("addi_W_rwe",     a_rwe, 1);
        check("addi_W_wb",      a_wb,  2'b00);
        check("addi_W_alu",     a_alu, 4'b0000);
        check("addi_W_imm",     a_imm, 1);
        check("addi_W_pc",      a_pc,  4'b0100);
        check("addi_W_retired", a_ret, 1);
        step(); #1;
        check("addi_next_F_ir_write", a_irw, 1);
        check("addi_next_F_retired",  a_ret, 0);

        // SUB x3,x1,x2
        set_instr(7'b0110011, 3'b000, 7'b0100000); #1;
        step(); step(); #1;
        check("sub_E_alu", a_alu, 4'b0001);
        check("sub_E_imm", a_imm, 0);
        step(); #1;
        check("sub_W_rwe", a_rwe, 1);
        step();

        // LW with three wait cycles; ready arrives on the cycle the counter would time out
        set_instr(7'b0000011, 3'b010, 7'b0000000); #1;
        step(); step();
        mem_ready = 1'b0; #1;
        check("lw_E_mem_req", a_req, 0);
        check("lw_E_imm",     a_imm, 1);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check($sformatf("lw_M%0d_mem_req", i), a_req,  1);
            check($sformatf("lw_M%0d_asel", i),    a_asel, 1);
            check($sformatf("lw_M%0d_we", i),      a_we,   0);
        end
        step(); mem_ready = 1'b1; #1;
        check("lw_M3_mem_req", a_req,  1);
        check("lw_M3_size",    a_size, 2'b10);
        check("lw_M3_retired", a_ret,  0);
        step(); #1;
        check("lw_W_wb",      a_wb,   2'b01);
        check("lw_W_rwe",     a_rwe,  1);
        check("lw_W_size",    a_size, 2'b10);
        check("lw_W_retired", a_ret,  1);
        check("lw_W_no_bus",  a_bus,  0);
        step();

        // SW, ready immediately: F D E M
        set_instr(7'b0100011, 3'b010, 7'b0000000); #1;
        step(); step(); step(); #1;
        check("sw_M_we",      a_we,  1);
        check("sw_M_retired", a_ret, 1);
        check("sw_M_pc",      a_pc,  4'b0100);
        step(); #1;
        check("sw_next_F_ir_write", a_irw, 1);

        // BEQ taken, then not taken
        set_instr(7'b1100011, 3'b000, 7'b0000000); branch_taken = 1'b1; #1;
        step(); step(); #1;
        check("beq_t_E_pc",      a_pc,  4'b0110);
        check("beq_t_E_rwe",     a_rwe, 0);
        check("beq_t_E_retired", a_ret, 1);
        step(); #1;
        check("beq_t_next_F_ir_write", a_irw, 1);
        branch_taken = 1'b0;
        step(); step(); #1;
        check("beq_nt_E_pc", a_pc, 4'b0100);
        step();

        // JAL
        set_instr(7'b1101111, 3'b000, 7'b0000000); #1;
        step(); step(); #1;
        check("jal_E_rwe",     a_rwe, 1);
        check("jal_E_wb",      a_wb,  2'b10);
        check("jal_E_pc",      a_pc,  4'b0110);
        check("jal_E_retired", a_ret, 1);
        step();

        // SW interrupted by reset mid-MEMORY
        set_instr(7'b0100011, 3'b010, 7'b0000000); #1;
        step(); step();
        mem_ready = 1'b0;
        step(); #1;
        check("swr_M_we",      a_we,   1);
        check("swr_M_asel",    a_asel, 1);
        reset = 1'b1; mem_ready = 1'b1; #1;
        check("swr_rst_retired", a_ret, 0);
        check("swr_rst_we",      a_we,  0);
        step(); reset = 1'b0; #1;
        check("swr_F_asel",     a_asel, 0);
        check("swr_F_we",       a_we,   0);
        check("swr_F_retired",  a_ret,  0);
        check("swr_F_ir_write", a_irw,  1);

        // MUL x3,x1,x2: illegal on dut_a, handshake on dut_m
        set_instr(7'b0110011, 3'b000, 7'b0000001); #1;
        step(); #1;
        check("mul_D_a_illegal", a_ill, 0);
        step(); #1;
        check("mul_a_illegal",  a_ill,    1);
        check("mul_a_mem_req",  a_req,    0);
        check("mul_m_illegal",  m_ill,    0);
        check("mul_E0_start",   m_mstart, 1);
        check("mul_E0_alu",     m_alu,    4'b1010);
        check("mul_E0_rwe",     m_rwe,    0);
        step(); #1;
        check("mul_E1_start",   m_mstart, 0);
        check("mul_E1_alu",     m_alu,    4'b1010);
        step(); mul_done = 1'b1; #1;
        check("mul_E2_start",   m_mstart, 0);
        check("mul_E2_rwe",     m_rwe,    0);
        step(); mul_done = 1'b0; #1;
        check("mul_W_rwe",      m_rwe,    1);
        check("mul_W_wb",       m_wb,     2'b00);
        check("mul_W_retired",  m_ret,    1);
        check("mul_a_hold_ill", a_ill,    1);
        check("mul_a_trap_pc",  a_pc,     4'b0000);
        check("mul_a_trap_ret", a_ret,    0);

        // Fetch timeout on dut_a (MEM_TIMEOUT = 4)
        reset = 1'b1; mem_ready = 1'b0;
        step(); step(); reset = 1'b0; #1;
        check("to_rst_clears_ill", a_ill, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_wait%0d_bus", i), a_bus, 0);
            check($sformatf("to_wait%0d_req", i), a_req, 1);
            step(); #1;
        end
        check("to_bus_set",  a_bus, 1);
        check("to_trap_req", a_req, 0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = (i >= 10);
            step(); #1;
            check($sformatf("to_hold%0d_bus", i), a_bus, 1);
            check($sformatf("to_hold%0d_irw", i), a_irw, 0);
        end
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        check("to_rst_bus",  a_bus,  0);
        check("to_rst_req",  a_req,  1);
        check("to_rst_asel", a_asel, 0);

        // SRAI is legal with funct7 = 0100000
        set_instr(7'b0010011, 3'b101, 7'b0100000); #1;
        step(); step(); #1;
        check("srai_E_alu", a_alu, 4'b1001);
        check("srai_E_imm", a_imm, 1);
        step(); step();

        // R-type SLL with funct7 = 0100000 is illegal
        set_instr(7'b0110011, 3'b001, 7'b0100000); #1;
        step(); step(); #1;
        check("sll_alt_illegal", a_ill, 1);
        check("sll_alt_rwe",     a_rwe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
